uart_bram_streamer: RTL and testbench

Parametrised BRAM-to-UART streamer that sits between the result BRAM and the UART transmitter. On `start` it reads `length` words from `base_addr` upward, splits each DATA_W-bit word into UART_W-bit bytes (LSB byte first, top byte sign-extended), and hands each byte to the transmitter over the `send`/`busy` handshake. It adds run-time base and length, configurable BRAM read latency, multi-byte words, abort, and progress/completion reporting.

---
 rtl/uart_bram_streamer.sv | 157 +++++++++++++++
 tb/tb_uart_bram_streamer.sv | 339 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bram_streamer.sv
// uart_bram_streamer: reads a run of signed words from BRAM and streams them
// to a UART transmitter, least-significant byte first, with the top byte
// sign-extended. Supports run-time base/length, abort and completion status.
module uart_bram_streamer #(
    parameter int DATA_W = 9,
    parameter int UART_W = 8,
    parameter int ADDR_W = 16,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W-1:0] length,
    output logic              bram_en,
    output logic [ADDR_W-1:0] bram_addr,
    input  logic [DATA_W-1:0] bram_dout,
    input  logic              busy,
    output logic              send,
    output logic [UART_W-1:0] tx_data,
    output logic              active,
    output logic [ADDR_W-1:0] words_sent,
    output logic              bram_read_complete,
    output logic              done
);

    localparam int NBYTES = (DATA_W + UART_W - 1) / UART_W;
    localparam int EXT_W  = NBYTES * UART_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = (RD_LAT > 2) ? $clog2(RD_LAT) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);
    localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'((RD_LAT > 1) ? RD_LAT - 2 : 0);

    typedef enum logic [2:0] {
        S_IDLE, S_ADDR, S_RDWAIT, S_LOAD, S_TX, S_GUARD, S_WAITB, S_DONE
    } state_t;

    state_t             state, state_next;
    logic [ADDR_W-1:0]  base_reg, length_reg;
    logic [DATA_W-1:0]  word_reg;
    logic [IDX_W-1:0]   byte_idx;
    logic [CNT_W-1:0]   lat_cnt;
    logic [EXT_W-1:0]   word_ext;
    logic [UART_W-1:0]  cur_byte;
    logic [ADDR_W-1:0]  words_inc, addr_next;
    logic               accept, fire, byte_adv, word_done;

    assign active    = (state != S_IDLE) && (state != S_DONE);
    assign words_inc = words_sent + ADDR_W'(1);
    // A fresh run addresses base_addr directly since base_reg is loaded on the same edge.
    assign addr_next = accept ? base_addr : base_reg + words_inc;

    // Sign-extend the captured word and pick the byte under the current index.
    always_comb begin
        word_ext = {EXT_W{word_reg[DATA_W-1]}};
        word_ext[DATA_W-1:0] = word_reg;
        cur_byte = '0;
        for (int unsigned k = 0; k < NBYTES; k++) begin
            if (byte_idx == IDX_W'(k)) cur_byte = word_ext[k*UART_W +: UART_W];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state <= S_IDLE;
        else       state <= state_next;
    end

    // Next-state decode plus the one-cycle action strobes; abort overrides everything.
    always_comb begin
        state_next = state;
        accept     = 1'b0;
        fire       = 1'b0;
        byte_adv   = 1'b0;
        word_done  = 1'b0;
        case (state)
            S_IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (length == '0) ? S_DONE : S_ADDR;
                end
            end
            S_ADDR:   state_next = (RD_LAT == 1) ? S_LOAD : S_RDWAIT;
            S_RDWAIT: if (lat_cnt == LAT_LAST) state_next = S_LOAD;
            S_LOAD:   state_next = S_TX;
            S_TX: begin
                if (!busy) begin
                    fire       = 1'b1;
                    state_next = S_GUARD;
                end
            end
            S_GUARD:  state_next = S_WAITB;
            S_WAITB: begin
                if (!busy) begin
                    if (byte_idx != IDX_LAST) begin
                        byte_adv   = 1'b1;
                        state_next = S_TX;
                    end else begin
                        word_done  = 1'b1;
                        state_next = (words_inc == length_reg) ? S_DONE : S_ADDR;
                    end
                end
            end
            S_DONE:   state_next = S_IDLE;
            default:  state_next = S_IDLE;
        endcase
        if (abort && state != S_IDLE) begin
            state_next = S_IDLE;
            fire       = 1'b0;
            byte_adv   = 1'b0;
            word_done  = 1'b0;
        end
    end

    // Datapath and registered outputs, driven from the next-state decode so
    // each strobe lines up with the cycle spent in its state.
    always_ff @(posedge clk) begin
        if (reset) begin
            bram_en            <= 1'b0;
            bram_addr          <= '0;
            send               <= 1'b0;
            tx_data            <= '0;
            words_sent         <= '0;
            bram_read_complete <= 1'b0;
            done               <= 1'b0;
            base_reg           <= '0;
            length_reg         <= '0;
            word_reg           <= '0;
            byte_idx           <= '0;
            lat_cnt            <= '0;
        end else begin
            bram_en <= (state_next == S_ADDR);
            send    <= fire;
            done    <= (state_next == S_DONE);
            if (accept) begin
                base_reg           <= base_addr;
                length_reg         <= length;
                words_sent         <= '0;
                byte_idx           <= '0;
                bram_read_complete <= 1'b0;
            end
            if (state_next == S_DONE) bram_read_complete <= 1'b1;
            if (state_next == S_ADDR) bram_addr <= addr_next;
            if (state == S_ADDR)        lat_cnt <= '0;
            else if (state == S_RDWAIT) lat_cnt <= lat_cnt + CNT_W'(1);
            if (state == S_LOAD) begin
                word_reg <= bram_dout;
                byte_idx <= '0;
            end
            if (byte_adv)  byte_idx   <= byte_idx + IDX_W'(1);
            if (fire)      tx_data    <= cur_byte;
            if (word_done) words_sent <= words_inc;
        end
    end

endmodule

// File: tb/tb_uart_bram_streamer.sv
// Bench for uart_bram_streamer: a default instance and an RD_LAT=3 instance,
// each with its own BRAM and transmitter model; sent bytes are checked
// against a queue of expected bytes filled when each run is started.
module tb_uart_bram_streamer;

    localparam logic [8:0] GARBAGE = 9'h155;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [8:0] mem [16];

    // default instance signals
    logic        start0 = 1'b0, abort0 = 1'b0, stall0 = 1'b0;
    logic [15:0] base0 = '0, len0 = '0;
    logic        en0, send0, active0, brc0, done0, busy0;
    logic [15:0] addr0, ws0;
    logic [8:0]  dout0;
    logic [7:0]  tx0;

    // RD_LAT=3 instance signals
    logic        start3 = 1'b0;
    logic [15:0] base3 = '0, len3 = '0;
    logic        en3, send3, active3, brc3, done3, busy3;
    logic [15:0] addr3, ws3;
    logic [8:0]  dout3;
    logic [7:0]  tx3;

    uart_bram_streamer u_dut (
        .clk(clk), .reset(reset), .start(start0), .abort(abort0),
        .base_addr(base0), .length(len0), .bram_en(en0), .bram_addr(addr0),
        .bram_dout(dout0), .busy(busy0), .send(send0), .tx_data(tx0),
        .active(active0), .words_sent(ws0), .bram_read_complete(brc0), .done(done0)
    );

    uart_bram_streamer #(.RD_LAT(3)) u_dut3 (
        .clk(clk), .reset(reset), .start(start3), .abort(1'b0),
        .base_addr(base3), .length(len3), .bram_en(en3), .bram_addr(addr3),
        .bram_dout(dout3), .busy(busy3), .send(send3), .tx_data(tx3),
        .active(active3), .words_sent(ws3), .bram_read_complete(brc3), .done(done3)
    );

    // BRAM models: data valid only in the exact cycle RD_LAT after bram_en.
    logic        v0a, v0b, v3a, v3b, v3c;
    logic [15:0] a0a, a0b, a3a, a3b, a3c;
    always @(posedge clk) begin
        v0a <= en0;  a0a <= addr0;  v0b <= v0a;  a0b <= a0a;
        v3a <= en3;  a3a <= addr3;  v3b <= v3a;  a3b <= a3a;  v3c <= v3b;  a3c <= a3b;
    end
    assign dout0 = v0b ? mem[a0b[3:0]] : GARBAGE;
    assign dout3 = v3c ? mem[a3c[3:0]] : GARBAGE;

    // Transmitter models: busy for 10 cycles after each send, plus a stall override.
    int bcnt0 = 0, bcnt3 = 0;
    always @(posedge clk) begin
        if (reset)          bcnt0 <= 0;
        else if (send0)     bcnt0 <= 10;
        else if (bcnt0 > 0) bcnt0 <= bcnt0 - 1;
        if (reset)          bcnt3 <= 0;
        else if (send3)     bcnt3 <= 10;
        else if (bcnt3 > 0) bcnt3 <= bcnt3 - 1;
    end
    assign busy0 = (bcnt0 != 0) || stall0;
    assign busy3 = (bcnt3 != 0);

    task automatic check_eq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
        end
    endtask

    function automatic logic [7:0] ext_byte(input logic [8:0] w, input int k);
        logic [15:0] e;
        e = {{7{w[8]}}, w};
        return e[k*8 +: 8];
    endfunction

    logic [7:0]  q0[$];
    logic [7:0]  q3[$];
    logic [15:0] aq3[$];
    logic [7:0]  last_tx = '0;
    int send_cnt0 = 0, en_cnt0 = 0, done_cnt0 = 0;
    int sends3 = 0, en_cyc3 = 0;
    logic prev_send0 = 1'b0, prev_send3 = 1'b0;

    // Scoreboard monitor, default instance.
    always @(negedge clk) begin : mon0
        logic [7:0] e;
        if (send0) begin
            check_eq("send_b2b", 32'(prev_send0), 32'd0);
            check_eq("send_busy", 32'(busy0), 32'd0);
            if (q0.size() == 0) check_eq("unexpected_send", 32'(tx0), 32'hDEAD);
            else begin
                e = q0.pop_front();
                check_eq("tx_byte", 32'(tx0), 32'(e));
                last_tx <= e;
            end
            send_cnt0 <= send_cnt0 + 1;
        end
        prev_send0 <= send0;
        if (en0)   en_cnt0   <= en_cnt0 + 1;
        if (done0) done_cnt0 <= done_cnt0 + 1;
    end

    // Scoreboard monitor, RD_LAT=3 instance: address order and read-to-send latency.
    always @(negedge clk) begin : mon3
        if (en3) begin
            if (aq3.size() == 0) check_eq("unexpected_en3", 32'(addr3), 32'hDEAD);
            else check_eq("wrap_addr", 32'(addr3), 32'(aq3.pop_front()));
            en_cyc3 <= cyc;
        end
        if (send3) begin
            check_eq("send3_b2b", 32'(prev_send3), 32'd0);
            if (q3.size() == 0) check_eq("unexpected_send3", 32'(tx3), 32'hDEAD);
            else check_eq("tx3_byte", 32'(tx3), 32'(q3.pop_front()));
            if (sends3 % 2 == 0) check_eq("load_lat", 32'(cyc - en_cyc3), 32'd5);
            sends3 <= sends3 + 1;
        end
        prev_send3 <= send3;
    end

    task automatic tick;
        @(negedge clk);
        #1;
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic push_word0(input logic [8:0] w);
        q0.push_back(ext_byte(w, 0));
        q0.push_back(ext_byte(w, 1));
    endtask

    task automatic wait_done0(input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (done0) seen = 1'b1;
        end
        check_eq("done_timeout", 32'(seen), 32'd1);
    endtask

    task automatic wait_sends0(input int target, input int budget);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            tick();
            if (send_cnt0 >= target) seen = 1'b1;
        end
        check_eq("send_timeout", 32'(seen), 32'd1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_send"},   32'(send0),   32'd0);
        check_eq({tag, "_en"},     32'(en0),     32'd0);
        check_eq({tag, "_addr"},   32'(addr0),   32'd0);
        check_eq({tag, "_tx"},     32'(tx0),     32'd0);
        check_eq({tag, "_active"}, 32'(active0), 32'd0);
        check_eq({tag, "_ws"},     32'(ws0),     32'd0);
        check_eq({tag, "_brc"},    32'(brc0),    32'd0);
        check_eq({tag, "_done"},   32'(done0),   32'd0);
    endtask

    task automatic start_run0(input logic [15:0] b, input logic [15:0] l);
        step();
        base0  = b;
        len0   = l;
        start0 = 1'b1;
        step();
        start0 = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int s, d, e;
        for (int i = 0; i < 16; i++) mem[i] = 9'(i * 7 + 3);
        mem[0]  = 9'd5;
        mem[1]  = 9'h1FF;   // -1
        mem[2]  = 9'h0FF;   // 255
        mem[3]  = 9'h100;   // -256
        mem[15] = 9'h13C;   // -196

        // reset state
        repeat (3) step();
        tick();
        check_all_zero("reset");
        step();
        reset = 1'b0;

        // full 4-word frame
        q0.push_back(8'h05); q0.push_back(8'h00);
        q0.push_back(8'hFF); q0.push_back(8'hFF);
        q0.push_back(8'hFF); q0.push_back(8'h00);
        q0.push_back(8'h00); q0.push_back(8'hFF);
        start_run0(16'h0000, 16'd4);
        tick();
        check_eq("t1_en_first", 32'(en0), 32'd1);
        check_eq("t1_addr_first", 32'(addr0), 32'd0);
        check_eq("t1_active", 32'(active0), 32'd1);
        check_eq("t1_ws_start", 32'(ws0), 32'd0);
        wait_done0(400);
        check_eq("t1_ws", 32'(ws0), 32'd4);
        check_eq("t1_brc", 32'(brc0), 32'd1);
        repeat (3) tick();
        check_eq("t1_done_cnt", 32'(done_cnt0), 32'd1);
        check_eq("t1_sends", 32'(send_cnt0), 32'd8);
        check_eq("t1_queue", 32'(q0.size()), 32'd0);

        // length zero
        s = send_cnt0; e = en_cnt0; d = done_cnt0;
        start_run0(16'h0000, 16'd0);
        tick();
        check_eq("t2_done", 32'(done0), 32'd1);
        check_eq("t2_active", 32'(active0), 32'd0);
        tick();
        check_eq("t2_done_pulse", 32'(done0), 32'd0);
        repeat (3) tick();
        check_eq("t2_no_en", 32'(en_cnt0), 32'(e));
        check_eq("t2_no_send", 32'(send_cnt0), 32'(s));
        check_eq("t2_done_cnt", 32'(done_cnt0), 32'(d + 1));
        check_eq("t2_brc", 32'(brc0), 32'd1);
        check_eq("t2_ws", 32'(ws0), 32'd0);

        // busy stall while in TX
        stall0 = 1'b1;
        push_word0(mem[0]);
        start_run0(16'h0000, 16'd1);
        repeat (54) begin
            tick();
            check_eq("stall_send", 32'(send0), 32'd0);
            check_eq("stall_hold", 32'(tx0), 32'(last_tx));
        end
        step();
        stall0 = 1'b0;
        tick();
        check_eq("release_early", 32'(send0), 32'd0);
        tick();
        check_eq("release_send", 32'(send0), 32'd1);
        check_eq("release_byte", 32'(tx0), 32'h05);
        wait_done0(100);
        check_eq("t3_ws", 32'(ws0), 32'd1);

        // abort in WAITB of word 2
        s = send_cnt0;
        for (int i = 0; i < 2; i++) push_word0(mem[i]);
        q0.push_back(ext_byte(mem[2], 0));
        start_run0(16'h0000, 16'd4);
        wait_sends0(s + 5, 300);
        step();
        abort0 = 1'b1;
        step();
        abort0 = 1'b0;
        tick();
        check_eq("abort_active", 32'(active0), 32'd0);
        check_eq("abort_ws", 32'(ws0), 32'd2);
        check_eq("abort_send", 32'(send0), 32'd0);
        check_eq("abort_en", 32'(en0), 32'd0);
        d = done_cnt0;
        repeat (20) tick();
        check_eq("abort_no_done", 32'(done_cnt0), 32'(d));
        check_eq("abort_brc", 32'(brc0), 32'd0);
        check_eq("abort_sends", 32'(send_cnt0), 32'(s + 5));
        for (int i = 0; i < 4; i++) push_word0(mem[i]);
        start_run0(16'h0000, 16'd4);
        wait_done0(400);
        check_eq("reabort_ws", 32'(ws0), 32'd4);
        check_eq("reabort_brc", 32'(brc0), 32'd1);

        // reset mid-transfer
        s = send_cnt0;
        for (int i = 0; i < 4; i++) push_word0(mem[i]);
        start_run0(16'h0000, 16'd4);
        wait_sends0(s + 3, 300);
        step();
        reset = 1'b1;
        q0.delete();
        step();
        tick();
        check_all_zero("midreset");
        step();
        reset = 1'b0;
        repeat (5) tick();
        check_eq("midreset_nosend", 32'(send_cnt0), 32'(s + 3));
        for (int i = 0; i < 4; i++) push_word0(mem[i]);
        start_run0(16'h0000, 16'd4);
        tick();
        check_eq("restart_ws", 32'(ws0), 32'd0);
        check_eq("restart_en", 32'(en0), 32'd1);
        wait_done0(400);
        check_eq("restart_ws_end", 32'(ws0), 32'd4);

        // address wrap with RD_LAT=3
        aq3.push_back(16'hFFFF);
        aq3.push_back(16'h0000);
        q3.push_back(ext_byte(mem[15], 0));
        q3.push_back(ext_byte(mem[15], 1));
        q3.push_back(ext_byte(mem[0], 0));
        q3.push_back(ext_byte(mem[0], 1));
        step();
        base3  = 16'hFFFF;
        len3   = 16'd2;
        start3 = 1'b1;
        step();
        start3 = 1'b0;
        begin
            bit seen = 1'b0;
            for (int i = 0; i < 300 && !seen; i++) begin
                tick();
                if (done3) seen = 1'b1;
            end
            check_eq("done3_timeout", 32'(seen), 32'd1);
        end
        check_eq("wrap_ws", 32'(ws3), 32'd2);
        check_eq("wrap_brc", 32'(brc3), 32'd1);
        repeat (3) tick();
        check_eq("wrap_addr_q", 32'(aq3.size()), 32'd0);
        check_eq("wrap_byte_q", 32'(q3.size()), 32'd0);
        check_eq("final_q0", 32'(q0.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
